// File: rtl/q_cmp_pkg.sv
// Shared types and elaboration helpers for the masked max/argmax comparator tree.
// Node values are carried sign- or zero-extended to Q_MAX_W so one compare serves both modes.
package q_cmp_pkg;

    localparam int Q_MAX_W   = 64;
    localparam int IDX_MAX_W = 16;

    typedef struct packed {
        logic [Q_MAX_W-1:0]   value;
        logic [IDX_MAX_W-1:0] idx;
        logic                 elig;
    } node_t;

    function automatic logic q_ge(input logic [Q_MAX_W-1:0] a,
                                  input logic [Q_MAX_W-1:0] b,
                                  input logic               signed_mode);
        if (signed_mode) return $signed(a) >= $signed(b);
        return a >= b;
    endfunction

    function automatic int tree_levels(input int n_act);
        return (n_act <= 1) ? 0 : $clog2(n_act);
    endfunction

    function automatic int stage_count(input int levels, input int lvl_per_stg);
        return (levels == 0) ? 1 : (levels + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

    // Number of nodes alive after k halving levels.
    function automatic int level_width(input int n_act, input int k);
        return (n_act + (1 << k) - 1) >> k;
    endfunction

    // Level 0 is the leaf row; it only gets a register when there is no tree at all.
    function automatic bit reg_after(input int k, input int levels, input int lvl_per_stg);
        if (levels == 0) return k == 0;
        return (k > 0) && ((k % lvl_per_stg == 0) || (k == levels));
    endfunction

endpackage

// File: rtl/q_cmp_node.sv
// Combinational two-input max node; a is the lower-index side and wins ties.
module q_cmp_node
    import q_cmp_pkg::*;
#(
    parameter bit SIGNED = 1'b0
) (
    input  node_t a,
    input  node_t b,
    output node_t y
);

    always_comb begin
        // NOTE: y gets a full default first so no path leaves it unassigned and no latch is inferred.
        y = a;
        if (a.elig && b.elig) begin
            if (!q_ge(a.value, b.value, SIGNED)) y = b;
        end else if (b.elig) begin
            y = b;
        end else if (!a.elig) begin
            y.value = '0;
        end
    end

endmodule

// File: rtl/q_argmax_pipe.sv
// Pipelined max/argmax over N_ACT masked Q-values behind a valid/ready stream.
// The comparator tree is cut by a register every LVL_PER_STG levels and after the last level.
module q_argmax_pipe
    import q_cmp_pkg::*;
#(
    parameter  int Q_W         = 16,
    parameter  int N_ACT       = 15,
    parameter  bit SIGNED      = 1'b0,
    parameter  int LVL_PER_STG = 1,
    localparam int IDX_W       = (N_ACT > 1) ? $clog2(N_ACT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_ACT*Q_W-1:0] q_vals,
    input  logic [N_ACT-1:0]     act_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Q_W-1:0]       max_q,
    output logic [IDX_W-1:0]     max_idx,
    output logic                 all_masked
);

    localparam int LEVELS = tree_levels(N_ACT);

    logic  adv;
    node_t fin;
    logic  unused_fin;

    // A single advance strobe: every stage shifts together or holds together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    function automatic node_t make_leaf(input logic [Q_W-1:0] q, input logic elig, input int idx);
        make_leaf      = '0;
        make_leaf.elig = elig;
        make_leaf.idx  = IDX_MAX_W'(idx);
        if (elig) begin
            if (SIGNED) make_leaf.value = Q_MAX_W'($signed(q));
            else        make_leaf.value = Q_MAX_W'(q);
        end
    endfunction

    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int W = level_width(N_ACT, k);
        node_t c_n [W];
        node_t r_n [W];
        logic  c_v;
        logic  r_v;

        if (k == 0) begin : g_leaf
            assign c_v = in_valid;
            for (genvar i = 0; i < W; i++) begin : g_in
                assign c_n[i] = make_leaf(q_vals[i*Q_W +: Q_W], act_mask[i], i);
            end
        end else begin : g_tree
            localparam int WP = level_width(N_ACT, k - 1);
            assign c_v = g_lvl[k-1].r_v;
            for (genvar j = 0; j < W; j++) begin : g_pair
                if (2*j + 1 < WP) begin : g_node
                    q_cmp_node #(.SIGNED(SIGNED)) u_node (
                        .a(g_lvl[k-1].r_n[2*j]),
                        .b(g_lvl[k-1].r_n[2*j+1]),
                        .y(c_n[j])
                    );
                end else begin : g_pass
                    assign c_n[j] = g_lvl[k-1].r_n[2*j];
                end
            end
        end

        if (reg_after(k, LEVELS, LVL_PER_STG)) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v <= 1'b0;
                    // NOTE: data flops are reset too so max_q/max_idx read 0 straight out of reset.
                    r_n <= '{default: '0};
                end else if (adv) begin
                    // NOTE: non-blocking so each stage captures its upstream's pre-edge value.
                    r_v <= c_v;
                    if (c_v) r_n <= c_n;
                end
            end
        end else begin : g_comb
            assign r_v = c_v;
            assign r_n = c_n;
        end
    end

    assign fin        = g_lvl[LEVELS].r_n[0];
    assign out_valid  = g_lvl[LEVELS].r_v;
    assign max_q      = fin.value[Q_W-1:0];
    assign max_idx    = fin.idx[IDX_W-1:0];
    assign all_masked = out_valid && !fin.elig;
    assign unused_fin = ^fin;

endmodule
